// File: rtl/ex_pair_dispatch.sv
// ID/EX boundary register for the dual-issue in-order pipeline.
// Splits a pair whose younger slot consumes the older slot's load result.
module ex_pair_dispatch #(
  parameter int DATA_WIDTH    = 64,
  parameter int RF_ADDR_WIDTH = 5,
  parameter int CTRL_WIDTH    = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     ex_stall,
  input  logic                     dec_valid,
  input  logic                     dec1_valid,
  output logic                     dec_ready,

  input  logic [RF_ADDR_WIDTH-1:0] dec0_rdaddr,
  input  logic                     dec0_RdWrtEn,
  input  logic                     dec0_LdEn,
  input  logic [RF_ADDR_WIDTH-1:0] dec0_rs1addr,
  input  logic [RF_ADDR_WIDTH-1:0] dec0_rs2addr,
  input  logic [DATA_WIDTH-1:0]    dec0_s1,
  input  logic [DATA_WIDTH-1:0]    dec0_s2,
  input  logic [CTRL_WIDTH-1:0]    dec0_ctrl,

  input  logic [RF_ADDR_WIDTH-1:0] dec1_rdaddr,
  input  logic                     dec1_RdWrtEn,
  input  logic                     dec1_LdEn,
  input  logic [RF_ADDR_WIDTH-1:0] dec1_rs1addr,
  input  logic [RF_ADDR_WIDTH-1:0] dec1_rs2addr,
  input  logic [DATA_WIDTH-1:0]    dec1_s1,
  input  logic [DATA_WIDTH-1:0]    dec1_s2,
  input  logic [CTRL_WIDTH-1:0]    dec1_ctrl,

  output logic                     issue0_valid,
  output logic [RF_ADDR_WIDTH-1:0] issue0_rdaddr,
  output logic                     issue0_RdWrtEn,
  output logic                     issue0_LdEn,
  output logic [RF_ADDR_WIDTH-1:0] issue0_rs1addr,
  output logic [RF_ADDR_WIDTH-1:0] issue0_rs2addr,
  output logic [DATA_WIDTH-1:0]    issue0_s1,
  output logic [DATA_WIDTH-1:0]    issue0_s2,
  output logic [CTRL_WIDTH-1:0]    issue0_ctrl,

  output logic                     issue1_valid,
  output logic [RF_ADDR_WIDTH-1:0] issue1_rdaddr,
  output logic                     issue1_RdWrtEn,
  output logic                     issue1_LdEn,
  output logic [RF_ADDR_WIDTH-1:0] issue1_rs1addr,
  output logic [RF_ADDR_WIDTH-1:0] issue1_rs2addr,
  output logic [DATA_WIDTH-1:0]    issue1_s1,
  output logic [DATA_WIDTH-1:0]    issue1_s2,
  output logic [CTRL_WIDTH-1:0]    issue1_ctrl,

  output logic [31:0]              split_count
);

  typedef struct packed {
    logic [RF_ADDR_WIDTH-1:0] rdaddr;
    logic                     rd_wrt_en;
    logic                     ld_en;
    logic [RF_ADDR_WIDTH-1:0] rs1addr;
    logic [RF_ADDR_WIDTH-1:0] rs2addr;
    logic [DATA_WIDTH-1:0]    s1;
    logic [DATA_WIDTH-1:0]    s2;
    logic [CTRL_WIDTH-1:0]    ctrl;
  } slot_t;

  localparam logic ST_PAIR  = 1'b0;
  localparam logic ST_SPLIT = 1'b1;

  logic        r_state;
  slot_t       r_issue0;
  slot_t       r_issue1;
  slot_t       r_hold;
  logic        r_issue0_valid;
  logic        r_issue1_valid;
  logic [31:0] r_split_count;

  slot_t       w_dec0;
  slot_t       w_dec1;
  logic        w_accept;
  logic        w_hazard;
  logic [31:0] w_split_count_inc;

  assign w_dec0 = '{rdaddr: dec0_rdaddr, rd_wrt_en: dec0_RdWrtEn, ld_en: dec0_LdEn,
                    rs1addr: dec0_rs1addr, rs2addr: dec0_rs2addr,
                    s1: dec0_s1, s2: dec0_s2, ctrl: dec0_ctrl};
  assign w_dec1 = '{rdaddr: dec1_rdaddr, rd_wrt_en: dec1_RdWrtEn, ld_en: dec1_LdEn,
                    rs1addr: dec1_rs1addr, rs2addr: dec1_rs2addr,
                    s1: dec1_s1, s2: dec1_s2, ctrl: dec1_ctrl};

  assign dec_ready = (r_state == ST_PAIR) && !ex_stall && !rst;
  assign w_accept  = dec_valid && dec_ready;

  // Only a load result is unavailable to EX forwarding; x0 is never a real producer.
  assign w_hazard = dec1_valid && dec0_LdEn && dec0_RdWrtEn &&
                    (dec0_rdaddr != '0) &&
                    ((dec0_rdaddr == dec1_rs1addr) || (dec0_rdaddr == dec1_rs2addr));

  assign w_split_count_inc = (r_split_count == 32'hFFFF_FFFF) ? r_split_count
                                                               : r_split_count + 32'd1;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= ST_PAIR;
      r_issue0_valid <= 1'b0;
      r_issue1_valid <= 1'b0;
      r_issue0       <= '0;
      r_issue1       <= '0;
      // NOTE: the hold buffer is reset too, so fields of an invalid slot are
      // never X even though nothing downstream should look at them.
      r_hold         <= '0;
      r_split_count  <= '0;
    end else if (flush) begin
      r_state        <= ST_PAIR;
      r_issue0_valid <= 1'b0;
      r_issue1_valid <= 1'b0;
      r_hold         <= '0;
    end else if (!ex_stall) begin
      if (r_state == ST_SPLIT) begin
        r_issue0       <= r_hold;
        r_issue0_valid <= 1'b1;
        r_issue1_valid <= 1'b0;
        r_state        <= ST_PAIR;
      end else if (w_accept) begin
        r_issue0       <= w_dec0;
        r_issue0_valid <= 1'b1;
        if (w_hazard) begin
          r_issue1_valid <= 1'b0;
          r_hold         <= w_dec1;
          r_state        <= ST_SPLIT;
          r_split_count  <= w_split_count_inc;
        end else begin
          r_issue1       <= w_dec1;
          r_issue1_valid <= dec1_valid;
        end
      end else begin
        r_issue0_valid <= 1'b0;
        r_issue1_valid <= 1'b0;
      end
    end
  end

  // Enables are gated by valid so a bubble can never look like a producer.
  assign issue0_valid   = r_issue0_valid;
  assign issue0_rdaddr  = r_issue0.rdaddr;
  assign issue0_RdWrtEn = r_issue0_valid & r_issue0.rd_wrt_en;
  assign issue0_LdEn    = r_issue0_valid & r_issue0.ld_en;
  assign issue0_rs1addr = r_issue0.rs1addr;
  assign issue0_rs2addr = r_issue0.rs2addr;
  assign issue0_s1      = r_issue0.s1;
  assign issue0_s2      = r_issue0.s2;
  assign issue0_ctrl    = r_issue0.ctrl;

  assign issue1_valid   = r_issue1_valid;
  assign issue1_rdaddr  = r_issue1.rdaddr;
  assign issue1_RdWrtEn = r_issue1_valid & r_issue1.rd_wrt_en;
  assign issue1_LdEn    = r_issue1_valid & r_issue1.ld_en;
  assign issue1_rs1addr = r_issue1.rs1addr;
  assign issue1_rs2addr = r_issue1.rs2addr;
  assign issue1_s1      = r_issue1.s1;
  assign issue1_s2      = r_issue1.s2;
  assign issue1_ctrl    = r_issue1.ctrl;

  assign split_count    = r_split_count;

endmodule

// File: tb/tb_ex_pair_dispatch.sv
// Scoreboard bench for ex_pair_dispatch: directed pair/split/stall/flush cases
// followed by a randomised stream, all compared through one check task.
module tb_ex_pair_dispatch;

  typedef struct packed {
    logic [4:0]  rd;
    logic        wen;
    logic        ld;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [63:0] s1;
    logic [63:0] s2;
    logic [31:0] ctrl;
  } slot_t;

  typedef struct packed {
    logic        v0;
    slot_t       s0;
    logic        v1;
    slot_t       s1;
    logic [31:0] cnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0, flush = 1'b0, ex_stall = 1'b0, dec_valid = 1'b0, dec1_valid = 1'b0;
  logic dec_ready;
  slot_t d0 = '0, d1 = '0;

  logic        issue0_valid, issue0_RdWrtEn, issue0_LdEn;
  logic [4:0]  issue0_rdaddr, issue0_rs1addr, issue0_rs2addr;
  logic [63:0] issue0_s1, issue0_s2;
  logic [31:0] issue0_ctrl;
  logic        issue1_valid, issue1_RdWrtEn, issue1_LdEn;
  logic [4:0]  issue1_rdaddr, issue1_rs1addr, issue1_rs2addr;
  logic [63:0] issue1_s1, issue1_s2;
  logic [31:0] issue1_ctrl;
  logic [31:0] split_count;

  int n_checks = 0;
  int n_pass   = 0;

  exp_t  sb[$];
  exp_t  m_out = '0;
  logic  m_split = 1'b0;
  slot_t m_hold = '0;

  always #5 clk = ~clk;

  ex_pair_dispatch dut (
    .clk(clk), .rst(rst), .flush(flush), .ex_stall(ex_stall),
    .dec_valid(dec_valid), .dec1_valid(dec1_valid), .dec_ready(dec_ready),
    .dec0_rdaddr(d0.rd), .dec0_RdWrtEn(d0.wen), .dec0_LdEn(d0.ld),
    .dec0_rs1addr(d0.rs1), .dec0_rs2addr(d0.rs2),
    .dec0_s1(d0.s1), .dec0_s2(d0.s2), .dec0_ctrl(d0.ctrl),
    .dec1_rdaddr(d1.rd), .dec1_RdWrtEn(d1.wen), .dec1_LdEn(d1.ld),
    .dec1_rs1addr(d1.rs1), .dec1_rs2addr(d1.rs2),
    .dec1_s1(d1.s1), .dec1_s2(d1.s2), .dec1_ctrl(d1.ctrl),
    .issue0_valid(issue0_valid), .issue0_rdaddr(issue0_rdaddr),
    .issue0_RdWrtEn(issue0_RdWrtEn), .issue0_LdEn(issue0_LdEn),
    .issue0_rs1addr(issue0_rs1addr), .issue0_rs2addr(issue0_rs2addr),
    .issue0_s1(issue0_s1), .issue0_s2(issue0_s2), .issue0_ctrl(issue0_ctrl),
    .issue1_valid(issue1_valid), .issue1_rdaddr(issue1_rdaddr),
    .issue1_RdWrtEn(issue1_RdWrtEn), .issue1_LdEn(issue1_LdEn),
    .issue1_rs1addr(issue1_rs1addr), .issue1_rs2addr(issue1_rs2addr),
    .issue1_s1(issue1_s1), .issue1_s2(issue1_s2), .issue1_ctrl(issue1_ctrl),
    .split_count(split_count)
  );

  task automatic check(input string tag, input logic [191:0] obs, input logic [191:0] exp);
    n_checks++;
    if (obs !== exp) $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    else n_pass++;
  endtask

  function automatic slot_t mk(input int rd, input bit wen, input bit ld,
                               input int rs1, input int rs2,
                               input logic [63:0] s1, input logic [63:0] s2);
    slot_t s;
    s.rd = 5'(rd); s.wen = wen; s.ld = ld; s.rs1 = 5'(rs1); s.rs2 = 5'(rs2);
    s.s1 = s1; s.s2 = s2; s.ctrl = 32'(rd * 256 + rs1 * 16 + rs2) ^ 32'hC0DE_0000;
    return s;
  endfunction

  function automatic slot_t rand_slot();
    slot_t s;
    s.rd   = 5'($urandom_range(0, 3));
    s.wen  = 1'($urandom_range(0, 1));
    s.ld   = 1'($urandom_range(0, 1));
    s.rs1  = 5'($urandom_range(0, 3));
    s.rs2  = 5'($urandom_range(0, 3));
    s.s1   = {$urandom(), $urandom()};
    s.s2   = {$urandom(), $urandom()};
    s.ctrl = $urandom();
    return s;
  endfunction

  // Reference behaviour for one clock edge; the result is what the DUT must show after it.
  task automatic model_edge(input logic r, input logic f, input logic st,
                            input logic dv, input logic d1v, input slot_t a, input slot_t b);
    bit hz;
    hz = d1v && a.ld && a.wen && (a.rd != 0) && (a.rd == b.rs1 || a.rd == b.rs2);
    if (r) begin
      m_out = '0; m_split = 1'b0; m_hold = '0;
    end else if (f) begin
      m_out.v0 = 1'b0; m_out.v1 = 1'b0; m_split = 1'b0;
    end else if (st) begin
      // everything holds
    end else if (m_split) begin
      m_out.v0 = 1'b1; m_out.s0 = m_hold; m_out.v1 = 1'b0; m_split = 1'b0;
    end else if (dv) begin
      m_out.v0 = 1'b1; m_out.s0 = a;
      if (hz) begin
        m_out.v1 = 1'b0; m_hold = b; m_split = 1'b1;
        if (m_out.cnt != 32'hFFFF_FFFF) m_out.cnt = m_out.cnt + 1;
      end else begin
        m_out.v1 = d1v; m_out.s1 = b;
      end
    end else begin
      m_out.v0 = 1'b0; m_out.v1 = 1'b0;
    end
  endtask

  task automatic step(input logic r, input logic f, input logic st,
                      input logic dv, input logic d1v, input slot_t a, input slot_t b);
    exp_t  e;
    slot_t o0, o1;
    @(negedge clk);
    rst = r; flush = f; ex_stall = st; dec_valid = dv; dec1_valid = d1v; d0 = a; d1 = b;
    #1;
    check("dec_ready", 192'(dec_ready), 192'(!r && !st && !m_split));
    model_edge(r, f, st, dv, d1v, a, b);
    sb.push_back(m_out);
    @(posedge clk);
    #1;
    e  = sb.pop_front();
    o0 = {issue0_rdaddr, issue0_RdWrtEn, issue0_LdEn, issue0_rs1addr, issue0_rs2addr,
          issue0_s1, issue0_s2, issue0_ctrl};
    o1 = {issue1_rdaddr, issue1_RdWrtEn, issue1_LdEn, issue1_rs1addr, issue1_rs2addr,
          issue1_s1, issue1_s2, issue1_ctrl};
    check("issue0_valid", 192'(issue0_valid), 192'(e.v0));
    check("issue1_valid", 192'(issue1_valid), 192'(e.v1));
    check("issue0_RdWrtEn", 192'(issue0_RdWrtEn), 192'(e.v0 & e.s0.wen));
    check("issue0_LdEn", 192'(issue0_LdEn), 192'(e.v0 & e.s0.ld));
    check("issue1_RdWrtEn", 192'(issue1_RdWrtEn), 192'(e.v1 & e.s1.wen));
    check("issue1_LdEn", 192'(issue1_LdEn), 192'(e.v1 & e.s1.ld));
    if (e.v0) check("issue0_fields", 192'(o0), 192'(e.s0));
    if (e.v1) check("issue1_fields", 192'(o1), 192'(e.s1));
    check("split_count", 192'(split_count), 192'(e.cnt));
    if (r) begin
      check("rst_issue0_zero", 192'(o0), 192'(0));
      check("rst_issue1_zero", 192'(o1), 192'(0));
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, '0, '0);
  endtask

  slot_t alu5, use7, ld5, use5, ld0, use0, alu_raw, st_ld, st_use;

  initial begin
    alu5    = mk(5, 1, 0, 1, 2, 64'h1111, 64'h2222);
    use7    = mk(9, 1, 0, 7, 3, 64'h3333, 64'h4444);
    ld5     = mk(5, 1, 1, 4, 0, 64'hAAAA_0001, 64'hAAAA_0002);
    use5    = mk(6, 1, 0, 1, 5, 64'hBBBB_0001, 64'hBBBB_0002);
    ld0     = mk(0, 1, 1, 2, 3, 64'h5, 64'h6);
    use0    = mk(8, 1, 0, 0, 4, 64'h7, 64'h8);
    alu_raw = mk(5, 1, 0, 3, 3, 64'h9, 64'hA);
    st_ld   = mk(12, 1, 1, 1, 1, 64'hDEAD, 64'hBEEF);
    st_use  = mk(13, 0, 1, 12, 2, 64'hFACE, 64'hCAFE);

    // Reset, then the independent pair and the load-use split.
    step(1, 0, 0, 0, 0, '0, '0);
    step(1, 0, 0, 1, 1, alu5, use7);
    step(0, 0, 0, 1, 1, alu5, use7);
    step(0, 0, 0, 1, 1, ld5, use5);
    step(0, 0, 0, 1, 1, alu5, use7);  // offered while SPLIT: must not be taken
    idle(1);

    // Cases that must not split.
    step(0, 0, 0, 1, 1, ld0, use0);
    step(0, 0, 0, 1, 1, alu5, use5);
    step(0, 0, 0, 1, 0, ld5, use5);
    step(0, 0, 0, 0, 1, ld5, use5);
    step(0, 0, 0, 1, 1, mk(5, 0, 1, 0, 0, 64'h1, 64'h2), use5);
    step(0, 0, 0, 1, 1, alu_raw, use5);

    // Stall for three cycles inside SPLIT, then release.
    step(0, 0, 0, 1, 1, st_ld, st_use);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 1, 1, alu5, use7);
    step(0, 0, 0, 0, 0, '0, '0);
    idle(1);

    // Flush with stall while SPLIT: held slot is dropped.
    step(0, 0, 0, 1, 1, ld5, use5);
    step(0, 1, 1, 1, 1, alu5, use7);
    idle(2);

    // Flush overrides an accepted pair in PAIR.
    step(0, 1, 0, 1, 1, alu5, use7);
    idle(1);

    // Reset mid-stream after splits clears the counter.
    step(0, 0, 0, 1, 1, ld5, use5);
    step(0, 0, 0, 0, 0, '0, '0);
    step(0, 0, 0, 1, 1, ld5, use5);
    step(1, 0, 0, 1, 1, alu5, use7);
    idle(1);

    // Counter saturation: preset to all-ones, then force a split.
    @(negedge clk);
    force dut.r_split_count = 32'hFFFF_FFFF;
    #1 release dut.r_split_count;
    m_out.cnt = 32'hFFFF_FFFF;
    step(0, 0, 0, 1, 1, ld5, use5);
    idle(2);

    // Randomised stream with small register indices so hazards are frequent.
    for (int i = 0; i < 400; i++)
      step(1'($urandom_range(0, 39) == 0), 1'($urandom_range(0, 15) == 0),
           1'($urandom_range(0, 4) == 0), 1'($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 1)), rand_slot(), rand_slot());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ex_pair_dispatch.md
Name: ex_pair_dispatch

Overview:
- ID/EX boundary register for the dual-issue in-order pipeline.
- Captures a decoded instruction pair (slot0 older, slot1 younger) and drives the issue0/issue1 operand and control fields consumed by the EX-stage intra-pair forwarding logic.
- Removes intra-pair load-use hazards by splitting the pair: slot0 issues alone, slot1 is held and issues the next cycle as the oldest instruction.
- Honours downstream stall and pipeline flush.

Parameters:
- DATA_WIDTH, 64, operand width.
- RF_ADDR_WIDTH, 5, register-file address width.
- CTRL_WIDTH, 32, opaque per-slot control payload (ALU op, LdType, imm select, ...).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- flush  in  1  synchronous pipeline flush (branch/trap redirect)
- ex_stall  in  1  downstream hold; all state and outputs frozen
- dec_valid  in  1  decode offers a pair (slot0 always valid when asserted)
- dec1_valid  in  1  slot1 of the offered pair is valid
- dec_ready  out  1  pair accepted this cycle when dec_valid && dec_ready
- decN_rdaddr  in  RF_ADDR_WIDTH  N=0,1: destination register
- decN_RdWrtEn  in  1  register write enable
- decN_LdEn  in  1  instruction is a load
- decN_rs1addr, decN_rs2addr  in  RF_ADDR_WIDTH  source addresses
- decN_s1, decN_s2  in  DATA_WIDTH  register-file operand values
- decN_ctrl  in  CTRL_WIDTH  control payload
- issueN_valid  out  1  N=0,1: registered slot valid
- issueN_rdaddr, issueN_RdWrtEn, issueN_LdEn, issueN_rs1addr, issueN_rs2addr, issueN_s1, issueN_s2, issueN_ctrl  out  as inputs  registered fields
- split_count  out  32  saturating count of pair splits

Behaviour:
- Reset (rst=1 at clk edge):
  - All issue outputs zero; state PAIR; hold buffer cleared; split_count=0.
- States:
  - PAIR: normal acceptance.
  - SPLIT: slot1 of the previous pair is held.
- dec_ready = (state==PAIR) && !ex_stall && !rst. Combinational; no dependence on dec_valid.
- Hazard: hz = dec1_valid && dec0_LdEn && dec0_RdWrtEn && dec0_rdaddr!=0 && (dec0_rdaddr==dec1_rs1addr || dec0_rdaddr==dec1_rs2addr).
- PAIR, accept (dec_valid && dec_ready):
  - If !hz: issue0 <= slot0; issue1 <= slot1; issue1_valid <= dec1_valid. Latency 1 cycle.
  - If hz:
    - issue0 <= slot0; issue1_valid <= 0.
    - hold buffer <= all slot1 fields.
    - state <= SPLIT; split_count += 1, saturating at 32'hFFFF_FFFF.
- PAIR, no accept and !ex_stall: bubble. issue0_valid=issue1_valid=0.
- SPLIT, !ex_stall:
  - issue0 <= hold buffer; issue0_valid <= 1; issue1_valid <= 0.
  - state <= PAIR.
  - The held slot's s1/s2 are issued unmodified; EX/MEM bypass resolves by address.
- Bubble gating: whenever issueN_valid=0, issueN_RdWrtEn and issueN_LdEn are 0, so no phantom forward or stall occurs downstream. Other fields of an invalid slot are don't-care but must be X-free after reset.
- ex_stall=1 (no flush): every register, state and split_count holds; dec_ready=0.
- flush=1:
  - Next edge: issue0_valid=issue1_valid=0 with enables gated; hold buffer discarded; state <= PAIR.
  - Overrides ex_stall and any simultaneous acceptance; the offered pair is dropped.
  - split_count is not reset.
- Priority: rst > flush > ex_stall > normal.
- rd==0 never triggers a split. Non-load RAW within a pair never splits (EX forwarding covers it).
- dec1_valid without dec_valid is ignored. dec_valid with dec1_valid=0 issues slot0 only and never splits.
- Reset or flush in SPLIT drops the held instruction; no issue occurs on the following cycle.

Test Plan:
- Independent pair: dec0 rd=5 ALU, dec1 rs1=7, both valid -> next cycle issue0_valid=issue1_valid=1, fields match, dec_ready stays 1, split_count=0.
- Load-use in pair: dec0 LdEn rd=5, dec1 rs2=5 -> cycle1 issue0=load, issue1_valid=0, dec_ready=0; cycle2 issue0=held slot1 (rs2addr=5, original s2), issue1_valid=0, dec_ready=1; split_count=1.
- rd=x0 load with dec1 rs1=0 -> no split, both slots issue together.
- ex_stall asserted for 3 cycles while in SPLIT -> outputs and state frozen, dec_ready=0; held slot issues on the first cycle after release.
- flush in SPLIT with ex_stall=1 -> next cycle both valids 0, issue0_RdWrtEn=issue0_LdEn=0, state PAIR, dec_ready=1; the held instruction never issues.
- rst mid-stream after 2 splits -> all outputs 0, split_count=0; preset split_count=32'hFFFF_FFFF and force a split -> stays 32'hFFFF_FFFF.
